mem_access_unit: RTL and testbench

Memory-stage responder for the MiniMIPS control path. Consumes the `MemRead`/`MemWrite` strobes the control decoder emits for `lw`/`sw`, runs a request/acknowledge transaction against a variable-latency data memory, and stalls the pipeline until the access completes. Sits between the EX/MEM pipeline register and the data memory port. Its `ReadData` output drives the `MemtoReg` writeback mux.

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage responder: turns lw/sw control strobes into a req/ack data-memory
// transaction and stalls the pipeline until it completes. Optional REQ timeout: MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              error_q, error_d;
    logic              start_s;
    logic              reject_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] timeout_unused_s;
    assign timeout_unused_s = 32'(TIMEOUT_CYC);
`endif

    assign start_s  = Valid & (MemRead ^ MemWrite) & (Addr[1:0] == 2'b00);
    assign reject_s = Valid & ((MemRead & MemWrite) | ((MemRead | MemWrite) & (Addr[1:0] != 2'b00)));

    // Stall is forced low while reset is held so an abandoned access releases the pipeline at once
    assign Stall     = rst_n & (((state_q == IDLE) & start_s) | (state_q == REQ));
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign Error     = error_q;

    // Next-state and datapath update for the IDLE/REQ/DONE transaction FSM
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        error_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    we_d    = MemWrite;
                    addr_d  = Addr;
                    wdata_d = WriteData;
                    state_d = REQ;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (reject_s) begin
                    error_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d  = mem_rdata;
                        rvalid_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b0;
                    end
                    state_d = DONE;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // ack in the last counted cycle is handled above, so it wins
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = REQ;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            error_q  <= error_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit; expectations come from transaction-level
// rules (stall = latency+1, req = latency, timeout clamp) rather than cycle-level state.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid, MemRead, MemWrite;
    logic [15:0] Addr;
    logic [31:0] WriteData;
    logic        Stall, ReadValid, Error, mem_req, mem_we, mem_ack;
    logic [31:0] ReadData, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData),
        .ReadValid(ReadValid), .Error(Error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs();
        Addr = 16'h0; WriteData = 32'h0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({Stall, ReadValid, Error, mem_req, mem_we} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got %b expected 00000", {Stall, ReadValid, Error, mem_req, mem_we});
        end
        checks++;
        if ({ReadData, mem_wdata, mem_addr} !== 80'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h expected 0", ReadData, mem_wdata, mem_addr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_rd = 32'h0;
        @(posedge clk); #1;
    endtask

    // One aligned access; lat = REQ cycle (1-based) in which ack is given
    task automatic run_access(input bit rd, input logic [15:0] addr, input logic [31:0] wd,
                              input int lat, input logic [31:0] rdat, input string nm);
        int stall_n = 0, req_n = 0, rv_n = 0, err_n = 0, cyc = 0, eff;
        bit done = 1'b0, stable_ok = 1'b1, to;
`ifdef MEM_TIMEOUT_EN
        to = (lat > TO);
`else
        to = 1'b0;
`endif
        eff = to ? TO : lat;
        Valid = 1'b1; MemRead = rd; MemWrite = !rd; Addr = addr; WriteData = wd;
        while (!done && cyc < 64) begin
            if (mem_req) begin
                mem_ack   = (req_n + 1 == lat);
                mem_rdata = mem_ack ? rdat : $urandom;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            @(negedge clk);
            if (ReadValid) rv_n++;
            if (Error) err_n++;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== addr || mem_we !== !rd || mem_wdata !== wd) stable_ok = 1'b0;
            end
            if (Stall) begin
                stall_n++;
            end else if (stall_n > 0) begin
                done = 1'b1;
                if (rd && !to) exp_rd = rdat;
                checks++;
                if (ReadData !== exp_rd) begin
                    errors++; $display("FAIL %s readdata got %h expected %h", nm, ReadData, exp_rd);
                end
            end
            cyc++;
            @(posedge clk); #1;
            if (done) idle_inputs();
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout got no completion expected DONE", nm); end
        checks++;
        if (stall_n != eff + 1) begin errors++; $display("FAIL %s stall_cycles got %0d expected %0d", nm, stall_n, eff + 1); end
        checks++;
        if (req_n != eff) begin errors++; $display("FAIL %s req_cycles got %0d expected %0d", nm, req_n, eff); end
        checks++;
        if (!stable_ok) begin errors++; $display("FAIL %s req_stable got unstable expected stable addr %h", nm, addr); end
        checks++;
        if (rv_n != ((rd && !to) ? 1 : 0)) begin errors++; $display("FAIL %s readvalid_pulses got %0d expected %0d", nm, rv_n, (rd && !to) ? 1 : 0); end
        checks++;
        if (err_n != (to ? 1 : 0)) begin errors++; $display("FAIL %s error_pulses got %0d expected %0d", nm, err_n, to ? 1 : 0); end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({Stall, mem_req, ReadValid, Error} !== 4'b0000) begin
            errors++; $display("FAIL %s post_idle got %b expected 0000", nm, {Stall, mem_req, ReadValid, Error});
        end
        @(posedge clk); #1;
    endtask

    task automatic run_reject(input bit v, input bit rd, input bit wr, input logic [15:0] addr);
        bit exp_err = v && ((rd && wr) || ((rd || wr) && addr[1:0] != 2'b00));
        Valid = v; MemRead = rd; MemWrite = wr; Addr = addr; WriteData = $urandom;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL reject_nostall addr %h got stall %b req %b expected 0 0", addr, Stall, mem_req);
        end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        checks++;
        if (Error !== exp_err || mem_req !== 1'b0) begin
            errors++; $display("FAIL reject_error addr %h got %b req %b expected %b 0", addr, Error, mem_req, exp_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (Error !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b expected 0", Error); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_zero_wait();
        run_access(1'b1, 16'h0040, $urandom, 1, 32'hDEADBEEF, "load_zero_wait");
    endtask

    task automatic test_store_latency();
        run_access(1'b0, 16'h0100, 32'h12345678, 3, $urandom, "store_lat3");
    endtask

    task automatic test_reject();
        run_reject(1'b1, 1'b1, 1'b1, 16'h0040);
        run_reject(1'b1, 1'b1, 1'b0, 16'h0042);
        run_reject(1'b1, 1'b0, 1'b1, 16'h0101);
        run_reject(1'b0, 1'b1, 1'b0, 16'h0043);
        run_reject(1'b1, 1'b0, 1'b0, 16'h0042);
    endtask

    task automatic test_ack_idle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({ReadValid, mem_req, Stall} !== 3'b000 || ReadData !== exp_rd) begin
                errors++; $display("FAIL ack_idle got rv/req/stall %b data %h expected 000 %h", {ReadValid, mem_req, Stall}, ReadData, exp_rd);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        run_access(1'b1, 16'h0200, $urandom, 100, $urandom, "timeout_noack");
        run_access(1'b1, 16'h0204, $urandom, TO, 32'hCAFEF00D, "ack_last_cycle");
        run_access(1'b0, 16'h0208, $urandom, TO + 1, $urandom, "store_timeout");
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a;
            a = {16'($urandom) & 16'hFFFC};
            run_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 6), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid();
        Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 16'h0080; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mid_req got %b expected 1", mem_req); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || Stall !== 1'b0) begin
            errors++; $display("FAIL reset_mid_drop got req %b stall %b expected 0 0", mem_req, Stall);
        end
        exp_rd = 32'h0;
        idle_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1'b1, 16'h0084, $urandom, 2, 32'hA5A55A5A, "load_after_reset");
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_latency();
        test_reject();
        test_ack_idle();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_ack_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
